// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_mmio
// Brief   : Memory-mapped UART transmitter with a small TX FIFO.
//           Define UART_TX_PARITY_EN to append an even-parity bit.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_mmio #(
  parameter int          ADDRESS_WIDTH    = 32,
  parameter int          INSTR_DATA_WIDTH = 32,
  parameter int          FIFO_DEPTH       = 4,
  parameter logic [15:0] DIV_RESET        = 16'd434
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [1:0]                  RAM_SEL,
  input  logic                        MEM_WS,
  input  logic [ADDRESS_WIDTH-1:0]    Addr,
  input  logic [INSTR_DATA_WIDTH-1:0] WR_DATA,
  output logic [INSTR_DATA_WIDTH-1:0] RD_DATA,
  output logic                        TX,
  output logic                        TX_IRQ
);
  localparam int              c_aw    = $clog2(FIFO_DEPTH);
  localparam logic [c_aw:0]   c_depth = (c_aw+1)'(FIFO_DEPTH);
  localparam logic [c_aw:0]   c_one   = (c_aw+1)'(1);
  localparam logic [c_aw-1:0] c_pinc  = c_aw'(1);

  localparam logic [2:0] c_idle   = 3'd0;
  localparam logic [2:0] c_start  = 3'd1;
  localparam logic [2:0] c_data   = 3'd2;
  localparam logic [2:0] c_stop   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] c_parity = 3'd3;
`endif

  logic            sel, wr_en, push, pop, push_ok, full, empty, launch, baud_zero;
  logic [1:0]      reg_idx;
  logic [15:0]     reload;
  logic [7:0]      head_byte;
  logic [2:0]      state_q, state_d;
  logic [15:0]     baud_q, baud_d, div_q, div_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            tx_q, tx_d, ovf_q, ovf_d;
  logic [c_aw-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [c_aw:0]   cnt_q, cnt_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif
  logic            unused_bits;

  assign unused_bits = ^{Addr[ADDRESS_WIDTH-1:4], Addr[1:0], WR_DATA[INSTR_DATA_WIDTH-1:16]};

  assign sel       = (RAM_SEL == 2'b10);
  assign wr_en     = sel && MEM_WS;
  assign reg_idx   = Addr[3:2];
  assign push      = wr_en && (reg_idx == 2'd0);
  assign full      = (cnt_q == c_depth);
  assign empty     = (cnt_q == '0);
  assign head_byte = mem_q[rptr_q];
  assign baud_zero = (baud_q == 16'd0);
  // A divisor of 0 behaves as 1, so the reload value saturates at 0.
  assign reload    = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    launch  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      c_idle: launch = !empty;
      c_start: begin
        if (baud_zero) begin
          state_d = c_data;
          baud_d  = reload;
          bit_d   = 3'd0;
          tx_d    = shreg_q[0];
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      c_data: begin
        if (baud_zero) begin
          baud_d  = reload;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = c_parity;
            tx_d    = par_q;
`else
            state_d = c_stop;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shreg_q[1];
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      c_parity: begin
        if (baud_zero) begin
          state_d = c_stop;
          baud_d  = reload;
          tx_d    = 1'b1;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
`endif
      c_stop: begin
        if (baud_zero) begin
          if (!empty) begin
            launch = 1'b1;
          end else begin
            state_d = c_idle;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: begin
        state_d = c_idle;
        tx_d    = 1'b1;
      end
    endcase
    // Frame launch is shared by IDLE and the back-to-back path out of STOP.
    if (launch) begin
      shreg_d = head_byte;
      baud_d  = reload;
      state_d = c_start;
      tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = ^head_byte;
`endif
    end
  end

  assign pop = launch;

  always_comb begin
    // A push into a full FIFO still lands when the FSM frees a slot this cycle.
    push_ok = push && (!full || pop);
    wptr_d  = push_ok ? wptr_q + c_pinc : wptr_q;
    rptr_d  = pop ? rptr_q + c_pinc : rptr_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + c_one;
      2'b01:   cnt_d = cnt_q - c_one;
      default: cnt_d = cnt_q;
    endcase
    mem_d = mem_q;
    if (push_ok) mem_d[wptr_q] = WR_DATA[7:0];
    ovf_d = ovf_q;
    if (wr_en && (reg_idx == 2'd1)) ovf_d = 1'b0;
    if (push && full && !pop) ovf_d = 1'b1;
    div_d = (wr_en && (reg_idx == 2'd2)) ? WR_DATA[15:0] : div_q;
  end

  always_comb begin
    RD_DATA = '0;
    if (sel) begin
      case (reg_idx)
        2'd1:    RD_DATA[3:0]  = {ovf_q, (state_q != c_idle), empty, full};
        2'd2:    RD_DATA[15:0] = div_q;
        default: RD_DATA       = '0;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= c_idle;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
      div_q   <= DIV_RESET;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      div_q   <= div_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

  assign TX     = tx_q;
  assign TX_IRQ = empty && (state_q == c_idle);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_mmio
// Brief   : Self-checking bench for uart_tx_mmio; TX waveform is predicted
//           per cycle from the frame format, bytes and divisor.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_mmio;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int DEPTH   = 4;
  localparam int LOG_LEN = 32768;

  logic        CLK     = 1'b0;
  logic        RST     = 1'b1;
  logic [1:0]  RAM_SEL = 2'b00;
  logic        MEM_WS  = 1'b0;
  logic [31:0] Addr    = 32'd0;
  logic [31:0] WR_DATA = 32'd0;
  logic [31:0] RD_DATA;
  logic        TX;
  logic        TX_IRQ;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit tx_log [LOG_LEN];
  logic [7:0] exp_q [$];

  uart_tx_mmio #(
    .ADDRESS_WIDTH(32), .INSTR_DATA_WIDTH(32), .FIFO_DEPTH(DEPTH), .DIV_RESET(16'd434)
  ) dut (
    .CLK(CLK), .RST(RST), .RAM_SEL(RAM_SEL), .MEM_WS(MEM_WS), .Addr(Addr),
    .WR_DATA(WR_DATA), .RD_DATA(RD_DATA), .TX(TX), .TX_IRQ(TX_IRQ)
  );

  always #5 CLK = ~CLK;

  // tx_log[E] holds TX as it stands after rising edge number E.
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) if (cyc < LOG_LEN) tx_log[cyc] <= TX;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    RAM_SEL = 2'b10; MEM_WS = 1'b1; Addr = a; WR_DATA = d;
    @(posedge CLK); #1;
    RAM_SEL = 2'b00; MEM_WS = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    RAM_SEL = 2'b10; MEM_WS = 1'b0; Addr = a;
    #1 d = RD_DATA;
    RAM_SEL = 2'b00;
  endtask

  // Bit k of a frame: start, 8 data bits LSB first, optional even parity, stop.
  function automatic logic model_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (FB == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  // Expects exp_q frames back-to-back from edge 'first', then a quiet line.
  task automatic check_frames(input string tag, input int first, input int div);
    logic [127:0] obs, exp;
    int t, t_end;
    t_end = first + exp_q.size() * FB * div + 2 * FB;
    while (cyc < t_end + 2) @(posedge CLK);
    @(negedge CLK);
    check_eq({tag, "_pre_start"}, tx_log[first-1], 1'b1);
    t = first;
    foreach (exp_q[f]) begin
      obs = '0; exp = '0;
      for (int j = 0; j < FB * div; j++) begin
        obs[j] = tx_log[t+j];
        exp[j] = model_bit(exp_q[f], j / div);
      end
      check_eq($sformatf("%s_frame%0d", tag, f), obs, exp);
      t += FB * div;
    end
    obs = '0; exp = '0;
    for (int j = 0; j < 2 * FB; j++) begin
      obs[j] = tx_log[t+j];
      exp[j] = 1'b1;
    end
    check_eq({tag, "_idle_after"}, obs, exp);
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  b;
    int div_w, div_e, n, first, seen_low;
    logic [7:0] burst [6];
    burst = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E};

    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    check_eq("rst_tx", TX, 1'b1);
    check_eq("rst_irq", TX_IRQ, 1'b1);
    bus_read(32'd4, rd);  check_eq("rst_status", rd, 32'h2);
    bus_read(32'd8, rd);  check_eq("rst_div", rd, 32'd434);
    bus_read(32'd0, rd);  check_eq("rd_txdata", rd, 32'd0);
    bus_read(32'd12, rd); check_eq("rd_reserved", rd, 32'd0);

    // Same-cycle write and read of DIV returns the old value.
    RAM_SEL = 2'b10; MEM_WS = 1'b1; Addr = 32'd8; WR_DATA = 32'd4;
    #1 check_eq("div_prewrite", RD_DATA, 32'd434);
    @(posedge CLK); #1;
    RAM_SEL = 2'b00; MEM_WS = 1'b0;
    bus_read(32'd8, rd); check_eq("div_postwrite", rd, 32'd4);

    exp_q = '{8'h55};
    bus_write(32'd0, 32'h55);
    first = cyc + 1;
    check_eq("irq_busy", TX_IRQ, 1'b0);
    check_frames("d4_55", first, 4);
    check_eq("irq_after", TX_IRQ, 1'b1);

    // Six writes into an idle FIFO: one is popped immediately, four fill it, the sixth drops.
    bus_write(32'd8, 32'd2);
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      bus_write(32'd0, {24'd0, burst[i]});
      if (i == 0) first = cyc + 1;
      if (i < DEPTH + 1) exp_q.push_back(burst[i]);
      if (i == 4) begin bus_read(32'd4, rd); check_eq("burst_full", rd, 32'h5); end
      if (i == 5) begin bus_read(32'd4, rd); check_eq("burst_ovf", rd, 32'hD); end
    end
    check_frames("burst", first, 2);
    bus_read(32'd4, rd); check_eq("ovf_sticky", rd, 32'hA);
    bus_write(32'd4, 32'd0);
    bus_read(32'd4, rd); check_eq("ovf_clear", rd, 32'h2);

    // Unselected writes never push or change DIV; reads return 0.
    for (int s = 0; s < 4; s++) begin
      if (s != 2) begin
        RAM_SEL = s[1:0]; MEM_WS = 1'b1; Addr = 32'd0; WR_DATA = 32'h5A;
        #1 check_eq($sformatf("unsel_rd_sel%0d", s), RD_DATA, 32'd0);
        Addr = 32'd8; WR_DATA = 32'd9;
        @(posedge CLK); #1;
      end
    end
    RAM_SEL = 2'b00; MEM_WS = 1'b0;
    bus_write(32'd12, 32'hFFFF);
    Addr = 32'd4; #1 check_eq("unsel_rd_status", RD_DATA, 32'd0);
    Addr = 32'd8; #1 check_eq("unsel_rd_div", RD_DATA, 32'd0);
    seen_low = 0;
    repeat (8) begin @(negedge CLK); if (TX == 1'b0) seen_low = 1; end
    check_eq("unsel_no_frame", seen_low, 0);
    bus_read(32'd4, rd); check_eq("unsel_status", rd, 32'h2);
    bus_read(32'd8, rd); check_eq("unsel_div", rd, 32'd2);

    exp_q = '{8'h07};
    bus_write(32'd8, 32'd1);
    bus_write(32'd0, 32'h07);
    first = cyc + 1;
    check_frames("d1_07", first, 1);

    for (int it = 0; it < 12; it++) begin
      div_w = $urandom_range(0, 6);
      div_e = (div_w == 0) ? 1 : div_w;
      n     = $urandom_range(1, DEPTH + 2);
      bus_write(32'd8, div_w);
      bus_read(32'd8, rd); check_eq($sformatf("rnd%0d_div", it), rd, div_w);
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        bus_write(32'd0, {24'd0, b});
        if (i == 0) first = cyc + 1;
        if (i < DEPTH + 1) exp_q.push_back(b);
      end
      check_frames($sformatf("rnd%0d", it), first, div_e);
      bus_read(32'd4, rd);
      check_eq($sformatf("rnd%0d_status", it), rd, (n > DEPTH + 1) ? 32'hA : 32'h2);
      bus_write(32'd4, 32'd0);
      check_eq($sformatf("rnd%0d_irq", it), TX_IRQ, 1'b1);
    end

    // Reset in the middle of the data bits of a queued pair of zero bytes.
    bus_write(32'd8, 32'd4);
    bus_write(32'd0, 32'h00);
    first = cyc + 1;
    bus_write(32'd0, 32'h00);
    while (cyc < first + 14) @(posedge CLK);
    #1 check_eq("pre_rst_tx", TX, 1'b0);
    RST = 1'b1;
    @(posedge CLK); #1;
    check_eq("midrst_tx", TX, 1'b1);
    RST = 1'b0;
    bus_read(32'd4, rd); check_eq("midrst_status", rd, 32'h2);
    bus_read(32'd8, rd); check_eq("midrst_div", rd, 32'd434);
    seen_low = 0;
    repeat (60) begin @(negedge CLK); if (TX == 1'b0) seen_low = 1; end
    check_eq("midrst_no_frame", seen_low, 0);
    check_eq("midrst_irq", TX_IRQ, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the processor's external memory bus, alongside the instruction/data RAM. It decodes the processor's `RAM_SEL`, `Addr`, `MEM_WS` and `Reg2_Out` outputs, buffers written bytes in a small FIFO, and serialises them onto a TX line. It returns status and configuration words on a read-data output that the bus mux feeds back to the processor's `DATA` input.

## Interface
- `ADDRESS_WIDTH`, 32: width of `Addr`.
- `INSTR_DATA_WIDTH`, 32: width of `WR_DATA` and `RD_DATA`.
- `FIFO_DEPTH`, 4: TX FIFO entries; must be a power of two, at least 2.
- `DIV_RESET`, 16'd434: baud divisor after reset, in clocks per bit.

Ports:
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RST` input 1: reset, synchronous and active-high.
- `RAM_SEL` input 2: bus target select; this block is selected when it equals 2'b10.
- `MEM_WS` input 1: write strobe from the processor.
- `Addr` input `ADDRESS_WIDTH`: byte address. Only `Addr[3:2]` is decoded; `Addr[1:0]` and the upper bits are ignored.
- `WR_DATA` input `INSTR_DATA_WIDTH`: write data, connected to `Reg2_Out`.
- `RD_DATA` output `INSTR_DATA_WIDTH`: combinational read data. It is 0 when the block is not selected.
- `TX` output 1: serial line; idles high.
- `TX_IRQ` output 1: level signal, high while the FIFO is empty and the FSM is IDLE.

## Operation
Registers, indexed by `Addr[3:2]`:
- **0 TXDATA**: a write pushes `WR_DATA[7:0]`. Reads return 0.
- **1 STATUS**: read-only bits.
  - [0] full.
  - [1] empty.
  - [2] busy (FSM not IDLE).
  - [3] overflow (sticky).
  - Any write to STATUS clears overflow.
- **2 DIV**: [15:0] baud divisor, read/write.
- **3**: reserved. Reads return 0; writes are ignored.

FIFO:
- Circular buffer with read and write pointers plus an occupancy counter of `log2(FIFO_DEPTH)+1` bits. Pointers wrap modulo `FIFO_DEPTH`.
- Pushing while full drops the byte and sets overflow.
- Exception: a push while full in the same cycle as an FSM pop is accepted. The occupancy stays at `FIFO_DEPTH`.

FSM states: IDLE, START, DATA, STOP (plus PARITY when configured).
- **IDLE**: `TX` is 1. If the FIFO is non-empty, pop the head into an 8-bit shift register, load the baud counter, and go to START.
- **START**: `TX` is 0 for one bit time.
- **DATA**: 8 bits, LSB first. A 3-bit counter counts 0..7; the register shifts right at each bit boundary.
- **STOP**: `TX` is 1 for one bit time. At the end of STOP:
  - if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap);
  - otherwise go to IDLE.
- Bit time: the baud counter counts from `DIV-1` down to 0; a bit boundary occurs when it reaches 0. A `DIV` of 0 is treated as 1.
- A `DIV` write takes effect at the next counter reload, i.e. the next bit or frame start. The bit currently being sent is never stretched or shortened.
- `TX` is a registered output, so it never glitches.

## Timing
Reset values:
- `TX` = 1, `TX_IRQ` = 1.
- FIFO empty, overflow = 0, `DIV` = `DIV_RESET`, FSM = IDLE.
- `RD_DATA` is then 0, or the reset-state register contents if selected.

Reset applied mid-frame:
- `TX` returns to 1 at the reset edge.
- Queued bytes are discarded.

Latency:
- A TXDATA write at edge k into an empty FIFO with the FSM in IDLE is popped at edge k+1. `TX` falls after edge k+1.
- A frame lasts `10*DIV` clocks (`11*DIV` with parity).

Reads and writes:
- Reads are combinational from current register state.
- A write and a read of the same register in one cycle returns the pre-write value.
- Writes require `RAM_SEL`==2'b10 and `MEM_WS`==1 at the rising edge.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - a PARITY state is inserted between DATA and STOP;
  - it sends the even-parity bit (XOR of the 8 data bits);
  - a frame is 11 bit times.
- Not defined: no PARITY state; 10-bit frames (start bit, 8 data bits, stop bit).

## Test plan
- Reset, then read STATUS (`Addr`=4, `RAM_SEL`=2'b10) -> `RD_DATA`=0x2; `TX`=1; `TX_IRQ`=1. Read DIV -> 434.
- Write DIV=4, then TXDATA=0x55 -> `TX` falls one cycle after the write. Bit sequence 0,1,0,1,0,1,0,1,0,1, each bit held 4 clocks; IDLE after 40 clocks.
- DIV=2; write 0xA5, 0x3C, 0xFF, 0x00, 0x81, 0x7E in consecutive cycles -> first five accepted. STATUS shows full, then overflow (bit 3). Frames are back-to-back with no idle gap. Writing STATUS clears overflow.
- `RAM_SEL`=2'b00 with `MEM_WS`=1 and `Addr`=0 -> no push. `RD_DATA`=0 for any `Addr`.
- Assert `RST` mid-DATA state -> `TX`=1 on the next edge; STATUS=0x2; no further frames.
- With `UART_TX_PARITY_EN`, DIV=1, send 0x07 -> 11-bit frame with parity bit 1.
